// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Shares one flex_counter-style timing resource between NUM_REQ requesters.
//   Each requester asks for an interval of N enabled ticks. The block grants
//   the counter to one requester at a time in round-robin order. It loads the
//   requested length as the rollover value, then clears and runs the counter.
//   When the count completes, the owner receives a one-cycle done pulse.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   NUM_CNT_BITS  counter width
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   req        in   level request per requester; held until done or withdrawn
//   req_len    in   packed lengths, requester i at [i*NUM_CNT_BITS +: NUM_CNT_BITS]
//   tick_en    in   count qualifier (prescaler strobe)
//   grant      out  one-hot owner of the counter, zero when idle
//   done       out  one-cycle completion pulse to the owner
//   busy       out  high whenever the arbiter is not idle
//   cur_count  out  current counter value
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_len,
  input  logic                            tick_en,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [NUM_CNT_BITS-1:0]         cur_count
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [ID_W-1:0]         owner_reg, owner_next;
  logic [ID_W-1:0]         last_id_reg, last_id_next;
  logic [NUM_CNT_BITS-1:0] len_reg, len_next;

  // Round-robin selection results.
  logic                    sel_found;
  logic [ID_W-1:0]         sel_id;
  logic [ID_W:0]           cand;
  logic [NUM_CNT_BITS-1:0] sel_len;
  logic                    owner_req;

  // Per-requester views of the packed inputs.
  logic [NUM_CNT_BITS-1:0] len_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      owner_onehot;

  // Counter control and state.
  logic                    cnt_clear;
  logic                    cnt_enable;
  logic [NUM_CNT_BITS-1:0] count_reg, count_next;
  logic                    rollover_flag_reg, rollover_flag_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign len_arr[gi]      = req_len[gi*NUM_CNT_BITS +: NUM_CNT_BITS];
      assign owner_onehot[gi] = (owner_reg == ID_W'(gi));
    end
  endgenerate

  assign sel_len   = len_arr[sel_id];
  assign owner_req = req[owner_reg];

  // Scan starts at last_id+1 and wraps. cand carries one extra bit so
  // last_id + NUM_REQ never overflows before the wrap subtraction.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_id_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!sel_found && req[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[ID_W-1:0];
      end
    end
  end

  // State register and arbitration registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      owner_reg   <= '0;
      len_reg     <= '0;
      last_id_reg <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      len_reg     <= len_next;
      last_id_reg <= last_id_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    len_next     = len_reg;
    last_id_next = last_id_reg;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          owner_next = sel_id;
          len_next   = sel_len;
          state_next = (sel_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          state_next   = IDLE;
          last_id_next = owner_reg;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A withdrawn request wins over a rollover in the same cycle.
        if (!owner_req) begin
          state_next   = IDLE;
          last_id_next = owner_reg;
        end else if (rollover_flag_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next   = IDLE;
        last_id_next = owner_reg;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and counter-control logic.
  always_comb begin
    grant      = '0;
    done       = '0;
    busy       = (state_reg != IDLE);
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_clear = 1'b1;
      end
      LOAD: begin
        grant     = owner_onehot;
        cnt_clear = 1'b1;
      end
      RUN: begin
        grant      = owner_onehot;
        cnt_clear  = !owner_req;
        // Gating on the flag makes the counter park at the length
        // instead of rolling over to 1.
        cnt_enable = tick_en & ~rollover_flag_reg;
      end
      DONE: begin
        grant     = owner_onehot;
        done      = owner_onehot;
        cnt_clear = 1'b1;
      end
      default: begin
        grant = '0;
      end
    endcase
  end

  // flex_counter core. Clear is synchronous and has priority. After
  // rollover_val the count wraps to 1. The flag is registered together with
  // the count, so it rises on the same edge that the count reaches rollover_val.
  always_comb begin
    count_next         = count_reg;
    rollover_flag_next = rollover_flag_reg;
    if (cnt_clear) begin
      count_next         = '0;
      rollover_flag_next = 1'b0;
    end else if (cnt_enable) begin
      if (count_reg == len_reg) begin
        count_next = NUM_CNT_BITS'(1);
      end else begin
        count_next = count_reg + NUM_CNT_BITS'(1);
      end
      rollover_flag_next = (count_next == len_reg);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_reg         <= '0;
      rollover_flag_reg <= 1'b0;
    end else begin
      count_reg         <= count_next;
      rollover_flag_reg <= rollover_flag_next;
    end
  end

  assign cur_count = count_reg;

endmodule
